ndp_job_sched: RTL

- Round-robin scheduler that shares one NDP_unit and its scratch-pad read port among NUM_REQ requesters.
- Each requester submits partial-sum batches. A batch is up to BUFFER_SIZE scratch-pad chunks to feed into the unit.
- A job (a sequence of batches ending with a last batch) owns the unit exclusively until its result is drained, because the unit accumulates across batches.
- The block sits between the per-requester stream front-ends and the NDP_unit / scratch_pad read side. It drives data_out_addr, lock, in_done and reset for them.

---
 rtl/ndp_job_sched.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ndp_job_sched.sv
// Round-robin job scheduler sharing one NDP_unit and its scratch-pad read port among NUM_REQ requesters.
// Optional calc watchdog: define NDP_SCHED_WATCHDOG_EN.
module ndp_job_sched #(
  parameter int NUM_REQ      = 4,
  parameter int BUFFER_SIZE  = 5,
  parameter int CHUNK_W      = 6,
  parameter int ADDR_W       = 3,
  parameter int CALC_TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CHUNK_W-1:0] req_chunks,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         psum_done,
  output logic [ADDR_W-1:0]          buf_addr,
  output logic                       ndp_lock,
  output logic                       ndp_in_done,
  output logic                       ndp_reset,
  input  logic                       ndp_calc_done,
  output logic                       res_valid,
  output logic [2:0]                 res_id,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       err_clamp,
  output logic                       err_timeout
);
  typedef enum logic [2:0] {IDLE, ACCEPT, URST, FEED, WAIT_CALC, RESULT} st_e;

  st_e                st_q;
  logic [2:0]         rr_q, own_q, sel_q, res_id_q;
  logic               own_vld_q, last_q;
  logic [CHUNK_W-1:0] cnt_q, k_q;
  logic [NUM_REQ-1:0] req_ready_q, psum_done_q;
  logic [ADDR_W-1:0]  buf_addr_q;
  logic               lock_q, in_done_q, nreset_q, res_valid_q, busy_q, clamp_q;

  // Pad per-requester inputs to 8 entries so 3-bit indices stay in range.
  logic [CHUNK_W-1:0] chk [8];
  logic [7:0]         vld_pad, last_pad;
  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_on
      assign chk[g] = req_chunks[g*CHUNK_W +: CHUNK_W];
    end else begin : g_off
      assign chk[g] = '0;
    end
  end
  assign vld_pad  = 8'(req_valid);
  assign last_pad = 8'(req_last);

  logic [CHUNK_W-1:0] sel_chk, clamped;
  logic               over;
  assign sel_chk = chk[sel_q];
  assign over    = sel_chk > CHUNK_W'(BUFFER_SIZE);
  assign clamped = over ? CHUNK_W'(BUFFER_SIZE) : sel_chk;

  logic [2:0] rr_nxt;
  assign rr_nxt = (own_q == 3'(NUM_REQ-1)) ? 3'd0 : own_q + 3'd1;

  logic       pick_vld;
  logic [2:0] pick_idx;
  logic [3:0] c;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    c        = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      c = {1'b0, rr_q} + 4'(j);
      if (c >= 4'(NUM_REQ)) c = c - 4'(NUM_REQ);
      if (!pick_vld && vld_pad[c[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = c[2:0];
      end
    end
  end

`ifdef NDP_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(CALC_TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= IDLE;
      rr_q        <= '0;
      own_q       <= '0;
      own_vld_q   <= 1'b0;
      sel_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      psum_done_q <= '0;
      buf_addr_q  <= '0;
      lock_q      <= 1'b1;
      in_done_q   <= 1'b0;
      nreset_q    <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      clamp_q     <= 1'b0;
`ifdef NDP_SCHED_WATCHDOG_EN
      wd_q        <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      psum_done_q <= '0;
      nreset_q    <= 1'b0;
`ifdef NDP_SCHED_WATCHDOG_EN
      tmo_q       <= 1'b0;
`endif
      case (st_q)
        IDLE: begin
          if (own_vld_q) begin
            if (vld_pad[own_q]) begin
              sel_q       <= own_q;
              req_ready_q <= NUM_REQ'(1) << own_q;
              st_q        <= ACCEPT;
            end
          end else if (pick_vld) begin
            sel_q       <= pick_idx;
            req_ready_q <= NUM_REQ'(1) << pick_idx;
            st_q        <= ACCEPT;
          end
        end
        ACCEPT: begin
          cnt_q  <= clamped;
          last_q <= last_pad[sel_q];
          if (over) clamp_q <= 1'b1;
          if (own_vld_q) begin
            k_q        <= '0;
            buf_addr_q <= '0;
            lock_q     <= (clamped == '0);
            st_q       <= FEED;
          end else begin
            own_q     <= sel_q;
            own_vld_q <= 1'b1;
            busy_q    <= 1'b1;
            nreset_q  <= 1'b1;
            lock_q    <= 1'b1;
            in_done_q <= 1'b0;
            st_q      <= URST;
          end
        end
        URST: begin
          k_q        <= '0;
          buf_addr_q <= '0;
          lock_q     <= (cnt_q == '0);
          st_q       <= FEED;
        end
        FEED: begin
          if (k_q + CHUNK_W'(1) < cnt_q) begin
            k_q        <= k_q + CHUNK_W'(1);
            buf_addr_q <= ADDR_W'(k_q + CHUNK_W'(1));
          end else begin
            lock_q     <= 1'b1;
            buf_addr_q <= '0;
            if (last_q) begin
              in_done_q <= 1'b1;
              st_q      <= WAIT_CALC;
`ifdef NDP_SCHED_WATCHDOG_EN
              wd_q      <= '0;
`endif
            end else begin
              psum_done_q <= NUM_REQ'(1) << own_q;
              st_q        <= IDLE;
            end
          end
        end
        WAIT_CALC: begin
          if (ndp_calc_done) begin
            res_valid_q <= 1'b1;
            res_id_q    <= own_q;
            st_q        <= RESULT;
          end
`ifdef NDP_SCHED_WATCHDOG_EN
          else if (wd_q == WD_W'(CALC_TIMEOUT - 1)) begin
            // Abandon the hung job: scrub the unit and let the next requester in.
            tmo_q     <= 1'b1;
            nreset_q  <= 1'b1;
            in_done_q <= 1'b0;
            busy_q    <= 1'b0;
            own_vld_q <= 1'b0;
            rr_q      <= rr_nxt;
            st_q      <= IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            own_vld_q   <= 1'b0;
            rr_q        <= rr_nxt;
            st_q        <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign psum_done   = psum_done_q;
  assign buf_addr    = buf_addr_q;
  assign ndp_lock    = lock_q;
  assign ndp_in_done = in_done_q;
  assign ndp_reset   = nreset_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign busy        = busy_q;
  assign err_clamp   = clamp_q;
`ifdef NDP_SCHED_WATCHDOG_EN
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif
endmodule
